complex_phase_freq_discriminator: RTL and testbench

- Receive end of the complex sinusoid DDFS path. Converts a stream of complex samples (real/imag, signed 16-bit) into instantaneous phase, magnitude and a frequency control word estimate.
- Phase and frequency use the DDFS scaling: 2^32 LSB = one full turn. For a clean input, the recovered frequency word equals the DDFS i_freq_control that produced the samples.
- Uses an iterative CORDIC in vectoring mode, with a valid/ready input handshake. Sits after DDFS outputs or heterodyne mixer outputs (truncated to 16 bits) for loopback checks and demodulation.

---
 rtl/complex_phase_freq_discriminator.sv | 162 ++++++++++++++++
 tb/tb_complex_phase_freq_discriminator.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/complex_phase_freq_discriminator.sv
// Iterative vectoring CORDIC: complex sample -> phase, magnitude and the phase step
// between consecutive outputs (2^32 LSB = one turn, same scaling as the DDFS tuning word).
module complex_phase_freq_discriminator #(
    parameter int ITERATIONS = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [15:0] i_real,
    input  logic [15:0] i_imag,
    input  logic        i_valid,
    output logic        o_ready,
    output logic [31:0] o_phase,
    output logic [17:0] o_magnitude,
    output logic [31:0] o_freq_control,
    output logic        o_valid,
    output logic        o_freq_valid
);

    typedef enum logic [1:0] {IDLE, PRE, ITER, OUT} state_t;

    localparam logic [4:0] LAST_K = 5'(ITERATIONS - 1);

    state_t             state;
    logic [4:0]         k;
    logic               zero_in;
    logic               have_prev;
    logic [31:0]        prev;
    logic signed [15:0] cap_re;
    logic signed [15:0] cap_im;
    logic signed [18:0] re_ext;
    logic signed [18:0] im_ext;
    logic signed [18:0] x;
    logic signed [18:0] y;
    logic signed [18:0] x_sh;
    logic signed [18:0] y_sh;
    logic [31:0]        z;
    logic [31:0]        phase_res;

    function automatic logic [31:0] atan_lut(input logic [4:0] idx);
        case (idx)
            5'd0:    atan_lut = 32'h2000_0000;
            5'd1:    atan_lut = 32'h12E4_051E;
            5'd2:    atan_lut = 32'h09FB_385B;
            5'd3:    atan_lut = 32'h0511_11D4;
            5'd4:    atan_lut = 32'h028B_0D43;
            5'd5:    atan_lut = 32'h0145_D7E1;
            5'd6:    atan_lut = 32'h00A2_F61E;
            5'd7:    atan_lut = 32'h0051_7C55;
            5'd8:    atan_lut = 32'h0028_BE53;
            5'd9:    atan_lut = 32'h0014_5F2F;
            5'd10:   atan_lut = 32'h000A_2F98;
            5'd11:   atan_lut = 32'h0005_17CC;
            5'd12:   atan_lut = 32'h0002_8BE6;
            5'd13:   atan_lut = 32'h0001_45F3;
            5'd14:   atan_lut = 32'h0000_A2FA;
            5'd15:   atan_lut = 32'h0000_517D;
            5'd16:   atan_lut = 32'h0000_28BE;
            5'd17:   atan_lut = 32'h0000_145F;
            5'd18:   atan_lut = 32'h0000_0A30;
            5'd19:   atan_lut = 32'h0000_0518;
            5'd20:   atan_lut = 32'h0000_028C;
            5'd21:   atan_lut = 32'h0000_0146;
            5'd22:   atan_lut = 32'h0000_00A3;
            5'd23:   atan_lut = 32'h0000_0051;
            default: atan_lut = 32'h0000_0000;
        endcase
    endfunction

    // 19-bit extension leaves headroom so negating -32768 and the CORDIC gain never overflow
    assign re_ext    = {{3{cap_re[15]}}, cap_re};
    assign im_ext    = {{3{cap_im[15]}}, cap_im};
    assign x_sh      = x >>> k;
    assign y_sh      = y >>> k;
    // A zero vector has no angle; force phase 0 rather than the summed atan table
    assign phase_res = zero_in ? 32'h0 : z;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= IDLE;
            k              <= '0;
            zero_in        <= 1'b0;
            have_prev      <= 1'b0;
            prev           <= '0;
            o_ready        <= 1'b1;
            o_valid        <= 1'b0;
            o_freq_valid   <= 1'b0;
            o_phase        <= '0;
            o_magnitude    <= '0;
            o_freq_control <= '0;
        end else begin
            o_valid      <= 1'b0;
            o_freq_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_valid && o_ready) begin
                        zero_in <= (i_real == 16'h0) && (i_imag == 16'h0);
                        o_ready <= 1'b0;
                        state   <= PRE;
                    end
                end
                PRE: begin
                    k     <= '0;
                    state <= ITER;
                end
                ITER: begin
                    if (k == LAST_K) state <= OUT;
                    else             k     <= k + 5'd1;
                end
                OUT: begin
                    o_phase     <= phase_res;
                    o_magnitude <= x[17:0];
                    o_valid     <= 1'b1;
                    if (have_prev) begin
                        o_freq_control <= phase_res - prev;
                        o_freq_valid   <= 1'b1;
                    end
                    prev      <= phase_res;
                    have_prev <= 1'b1;
                    o_ready   <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath registers carry no reset; the FSM always loads them before use
    always_ff @(posedge i_clk) begin
        case (state)
            IDLE: begin
                if (i_valid && o_ready) begin
                    cap_re <= i_real;
                    cap_im <= i_imag;
                end
            end
            PRE: begin
                if (cap_re[15]) begin
                    x <= -re_ext;
                    y <= -im_ext;
                    z <= 32'h8000_0000;
                end else begin
                    x <= re_ext;
                    y <= im_ext;
                    z <= 32'h0;
                end
            end
            ITER: begin
                if (!y[18]) begin
                    x <= x + y_sh;
                    y <= y - x_sh;
                    z <= z + atan_lut(k);
                end else begin
                    x <= x - y_sh;
                    y <= y + x_sh;
                    z <= z - atan_lut(k);
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_complex_phase_freq_discriminator.sv
// Bench for complex_phase_freq_discriminator: real-math reference model (atan2/sqrt)
// checked every cycle, plus directed vectors with literal expectations.
module tb_complex_phase_freq_discriminator;

    localparam int  ITER   = 16;
    localparam int  LAT    = ITER + 3;
    localparam real TWO_PI = 6.283185307179586;
    localparam real GAIN   = 1.6467602581210654;
    localparam int  PH_TOL = 1 << 16;
    localparam int  FQ_TOL = 1 << 17;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic               vin;
    logic               ready;
    logic [31:0]        phase;
    logic [17:0]        mag;
    logic [31:0]        fc;
    logic               ov;
    logic               fv;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int     r;
        int     i;
        longint stamp;
    } smp_t;

    smp_t        q[$];
    longint      cyc        = 0;
    longint      last_stamp = -1000;
    int          accepts    = 0;
    int          fv_count   = 0;
    logic [31:0] last_fc    = '0;
    bit          m_have_prev = 1'b0;
    logic [31:0] m_prev      = '0;
    logic [31:0] acc         = '0;
    logic [31:0] ddfs_f      = '0;

    smp_t        s;
    logic [31:0] exp_ph;
    real         exp_mg;
    logic        exp_ready;

    complex_phase_freq_discriminator #(.ITERATIONS(ITER)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_real         (re),
        .i_imag         (im),
        .i_valid        (vin),
        .o_ready        (ready),
        .o_phase        (phase),
        .o_magnitude    (mag),
        .o_freq_control (fc),
        .o_valid        (ov),
        .o_freq_valid   (fv)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ideal_phase(input int r, input int i);
        real a;
        if (r == 0 && i == 0) return 32'h0;
        a = $atan2(real'(i), real'(r));
        if (a < 0.0) a = a + TWO_PI;
        return 32'(longint'(a / TWO_PI * 4294967296.0));
    endfunction

    function automatic real ideal_mag(input int r, input int i);
        real rr, ii;
        rr = real'(r);
        ii = real'(i);
        return GAIN * $sqrt(rr * rr + ii * ii);
    endfunction

    function automatic void mk(input logic [31:0] ph, input real amp, output int r, output int i);
        real a;
        a = real'(ph) * TWO_PI / 4294967296.0;
        r = int'(amp * $cos(a));
        i = int'(amp * $sin(a));
    endfunction

    task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_near(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
        logic signed [31:0] d;
        int ad;
        d  = act - exp;
        ad = (d < 0) ? -int'(d) : int'(d);
        checks++;
        if (ad > tol) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h +/- %0d", name, act, exp, tol);
        end
    endtask

    task automatic chk_mag(input string name, input logic [17:0] act, input real exp);
        real d, tol;
        d   = real'(act) - exp;
        if (d < 0.0) d = -d;
        tol = exp * 0.001 + 4.0;
        checks++;
        if (d > tol) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0.1f +/- %0.1f", name, act, exp, tol);
        end
    endtask

    // Record every accepted sample on the active edge
    always @(posedge clk) begin
        if (!rst && vin && ready) begin
            q.push_back('{int'(re), int'(im), cyc});
            last_stamp = cyc;
            accepts++;
        end
        cyc++;
    end

    always @(posedge clk) acc <= acc + ddfs_f;

    // Compare DUT against the reference model once per cycle
    always @(negedge clk) begin
        if (!rst) begin
            exp_ready = ((cyc - last_stamp) >= LAT);
            chk_eq("ready", 32'(ready), 32'(exp_ready));
            if (ov) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_valid: got o_valid=1, expected no pending sample");
                end else begin
                    s      = q.pop_front();
                    exp_ph = ideal_phase(s.r, s.i);
                    exp_mg = ideal_mag(s.r, s.i);
                    chk_eq("latency", 32'(cyc - s.stamp), 32'(LAT));
                    chk_near("phase", phase, exp_ph, PH_TOL);
                    chk_mag("magnitude", mag, exp_mg);
                    chk_eq("freq_valid", 32'(fv), 32'(m_have_prev));
                    if (m_have_prev && fv) begin
                        chk_near("freq", fc, exp_ph - m_prev, FQ_TOL);
                        last_fc = fc;
                        fv_count++;
                    end
                    m_prev      = exp_ph;
                    m_have_prev = 1'b1;
                end
            end else begin
                chk_eq("freq_valid_idle", 32'(fv), 32'h0);
            end
        end
    end

    task automatic send(input int r, input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got o_ready=0, expected 1 within 100 cycles");
        end
        re  = 16'(r);
        im  = 16'(i);
        vin = 1'b1;
        @(negedge clk);
        vin = 1'b0;
    endtask

    task automatic wait_out(output logic [31:0] ph, output logic [17:0] mg, output logic fvo,
                            output logic [31:0] fco);
        int n;
        n = 0;
        while (!ov && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!ov) begin
            checks++;
            errors++;
            $display("FAIL out_timeout: got o_valid=0, expected 1 within 60 cycles");
        end
        ph  = phase;
        mg  = mag;
        fvo = fv;
        fco = fc;
        @(negedge clk);
    endtask

    task automatic run_one(input int r, input int i, output logic [31:0] ph, output logic [17:0] mg,
                           output logic fvo, output logic [31:0] fco);
        send(r, i);
        wait_out(ph, mg, fvo, fco);
    endtask

    task automatic stream(input int cycles, input bit use_ddfs);
        int r, i;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            if (use_ddfs) mk(acc, 30000.0, r, i);
            else          mk($urandom, 30000.0, r, i);
            re  = 16'(r);
            im  = 16'(i);
            vin = 1'b1;
        end
        @(negedge clk);
        vin = 1'b0;
        repeat (LAT + 5) @(negedge clk);
    endtask

    task automatic loopback(input logic [31:0] f);
        int fv0;
        fv0    = fv_count;
        ddfs_f = f;
        stream(5 * LAT, 1'b1);
        ddfs_f = '0;
        chk_near("loop_freq", last_fc, f * 32'(LAT), FQ_TOL);
        chk_eq("loop_fv_count", 32'(fv_count - fv0), 32'd5);
    endtask

    logic [31:0] ph_o;
    logic [17:0] mg_o;
    logic        fv_o;
    logic [31:0] fc_o;
    int          acc0;

    initial begin
        rst = 1'b1;
        vin = 1'b0;
        re  = '0;
        im  = '0;
        repeat (3) @(negedge clk);
        chk_eq("rst_ready", 32'(ready), 32'h1);
        chk_eq("rst_valid", 32'(ov), 32'h0);
        chk_eq("rst_fvalid", 32'(fv), 32'h0);
        chk_eq("rst_phase", phase, 32'h0);
        chk_eq("rst_mag", 32'(mag), 32'h0);
        chk_eq("rst_freq", fc, 32'h0);
        rst = 1'b0;

        run_one(16384, 0, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_0", ph_o, 32'h0000_0000, PH_TOL);
        chk_near("lit_mag_0", 32'(mg_o), 32'd26981, 30);
        chk_eq("lit_first_fv", 32'(fv_o), 32'h0);

        run_one(0, 16384, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_90", ph_o, 32'h4000_0000, PH_TOL);
        chk_near("lit_freq_90", fc_o, 32'h4000_0000, FQ_TOL);
        run_one(-16384, 0, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_180", ph_o, 32'h8000_0000, PH_TOL);
        chk_near("lit_freq_180", fc_o, 32'h4000_0000, FQ_TOL);
        run_one(0, -16384, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_270", ph_o, 32'hC000_0000, PH_TOL);
        chk_near("lit_freq_270", fc_o, 32'h4000_0000, FQ_TOL);
        run_one(-32768, -32768, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_225", ph_o, 32'hA000_0000, PH_TOL);
        chk_near("lit_freq_225", fc_o, 32'hE000_0000, FQ_TOL);
        chk_near("lit_mag_max", 32'(mg_o), 32'd76313, 80);

        run_one(15137, -6270, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_f0", ph_o, 32'hF000_0000, PH_TOL);
        run_one(15137, 6270, ph_o, mg_o, fv_o, fc_o);
        chk_near("lit_phase_10", ph_o, 32'h1000_0000, PH_TOL);
        chk_near("lit_freq_wrap", fc_o, 32'h2000_0000, FQ_TOL);

        loopback(32'h000F_FFFF);
        loopback(32'h0000_FFFF);

        acc0 = accepts;
        stream(200, 1'b0);
        chk_eq("busy_accepts", 32'(accepts - acc0), 32'd11);

        send(16384, 16384);
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk_eq("arst_ready", 32'(ready), 32'h1);
        chk_eq("arst_valid", 32'(ov), 32'h0);
        chk_eq("arst_fvalid", 32'(fv), 32'h0);
        chk_eq("arst_phase", phase, 32'h0);
        chk_eq("arst_mag", 32'(mag), 32'h0);
        chk_eq("arst_freq", fc, 32'h0);
        q.delete();
        m_have_prev = 1'b0;
        last_stamp  = -1000;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_one(20000, 5000, ph_o, mg_o, fv_o, fc_o);
        chk_eq("post_rst_fv", 32'(fv_o), 32'h0);
        run_one(0, 0, ph_o, mg_o, fv_o, fc_o);
        chk_eq("zero_phase", ph_o, 32'h0);
        chk_eq("zero_mag", 32'(mg_o), 32'h0);
        chk_eq("zero_fv", 32'(fv_o), 32'h1);

        repeat (5) @(negedge clk);
        chk_eq("queue_drained", 32'(q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
